// File: rtl/jpeg_pkg.sv
// Shared constants and types for the JPEG inverse-zigzag path.
// ZIGZAG maps scan index k to natural position row*8+col.
package jpeg_pkg;

    localparam int COEF_W = 10;
    localparam int BLK_N  = 64;

    localparam logic [5:0] ZIGZAG [BLK_N] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/zigzag_rom.sv
// Combinational zigzag lookup: scan index k -> natural (row, col).
module zigzag_rom
    import jpeg_pkg::*;
(
    input  logic [5:0] i_k,
    output logic [2:0] o_row,
    output logic [2:0] o_col
);

    logic [5:0] w_nat;

    assign w_nat = ZIGZAG[i_k];
    assign o_row = w_nat[5:3];
    assign o_col = w_nat[2:0];

endmodule

// File: rtl/inverse_zigzag_buffer.sv
// Collects one zigzag-ordered 8x8 coefficient block and emits it row by row in raster order.
// Define PINGPONG_EN for two banks so the next block fills while the previous one drains.
module inverse_zigzag_buffer
    import jpeg_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [COEF_W-1:0]     in_coef,
    input  logic                  in_eob,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*COEF_W-1:0]   out_data,
    output logic [2:0]            out_row
);

    // state | meaning
    // FILL  | no block ready for readout; write side accepts coefficients
    // DRAIN | a closed block is presented one row per output transfer
    state_t     r_state;
    state_t     w_state_nxt;
    logic [5:0] r_k;
    logic [2:0] r_row;
    logic [2:0] w_wr_row;
    logic [2:0] w_wr_col;
    logic [5:0] w_wr_idx;
    logic [5:0] w_rd_idx;
    logic       w_in_fire;
    logic       w_out_fire;
    logic       w_close;
    logic       w_last_row;
    logic       w_swap;

    zigzag_rom u_zigzag_rom (
        .i_k   (r_k),
        .o_row (w_wr_row),
        .o_col (w_wr_col)
    );

    assign w_wr_idx   = {w_wr_row, w_wr_col};
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign w_close    = w_in_fire & (in_eob | (r_k == 6'd63));
    assign w_last_row = w_out_fire & (r_row == 3'd7);
    assign out_valid  = (r_state == DRAIN);
    assign out_row    = r_row;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FILL;
            r_k     <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_in_fire) begin
                r_k <= w_close ? 6'd0 : r_k + 6'd1;
            end
            if (w_swap) begin
                r_row <= '0;
            end else if (w_out_fire) begin
                r_row <= r_row + 3'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_swap) begin
            w_state_nxt = DRAIN;
        end else if (w_last_row) begin
            w_state_nxt = FILL;
        end
    end

`ifdef PINGPONG_EN
    logic [COEF_W-1:0] r_mem  [2][BLK_N];
    logic [BLK_N-1:0]  r_mask [2];
    logic              r_wbank;
    logic              r_wfull;
    logic              w_rbank;

    // A closed write bank waits in r_wfull until the read bank frees up.
    assign w_rbank  = ~r_wbank;
    assign in_ready = ~r_wfull;
    assign w_swap   = (r_wfull | w_close) & ((r_state == FILL) | w_last_row);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wbank   <= 1'b0;
            r_wfull   <= 1'b0;
            r_mask[0] <= '0;
            r_mask[1] <= '0;
        end else begin
            if (w_swap) begin
                r_wbank <= ~r_wbank;
                r_wfull <= 1'b0;
            end else if (w_close) begin
                r_wfull <= 1'b1;
            end
            if (w_last_row) begin
                r_mask[w_rbank] <= '0;
            end
            if (w_in_fire) begin
                r_mask[r_wbank][w_wr_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_mem[r_wbank][w_wr_idx] <= in_coef;
        end
    end

    always_comb begin
        out_data = '0;
        w_rd_idx = '0;
        for (int c = 0; c < 8; c++) begin
            w_rd_idx = {r_row, 3'(c)};
            out_data[(7-c)*COEF_W +: COEF_W] =
                r_mask[w_rbank][w_rd_idx] ? r_mem[w_rbank][w_rd_idx] : '0;
        end
    end
`else
    logic [COEF_W-1:0] r_mem [BLK_N];
    logic [BLK_N-1:0]  r_mask;

    assign in_ready = (r_state == FILL);
    assign w_swap   = w_close;

    // Unwritten positions read as zero, so clearing the mask replaces clearing storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mask <= '0;
        end else if (w_last_row) begin
            r_mask <= '0;
        end else if (w_in_fire) begin
            r_mask[w_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_mem[w_wr_idx] <= in_coef;
        end
    end

    always_comb begin
        out_data = '0;
        w_rd_idx = '0;
        for (int c = 0; c < 8; c++) begin
            w_rd_idx = {r_row, 3'(c)};
            out_data[(7-c)*COEF_W +: COEF_W] = r_mask[w_rd_idx] ? r_mem[w_rd_idx] : '0;
        end
    end
`endif

endmodule
